// File: rtl/linebuf_writer.sv
// Line-buffer write side: packs 8-bit pixels into 64-bit words and writes them into a
// NUM_ROWS_BUF-row ring on RAM port A, reporting to the reader how many complete rows are resident.
module linebuf_writer #(
    parameter int IMG_WIDTH    = 64,
    parameter int IMG_HEIGHT   = 64,
    parameter int NUM_ROWS_BUF = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  pixel_data,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic        ena,
    output logic        wea,
    output logic [7:0]  addra,
    output logic [63:0] dina,
    input  logic        row_release,
    output logic [3:0]  rows_avail,
    output logic        row_done,
    output logic        frame_done
);
    localparam int WPR = IMG_WIDTH / 8;
    localparam int WW  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int SW  = (NUM_ROWS_BUF > 1) ? $clog2(NUM_ROWS_BUF) : 1;
    localparam int RW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
    state_t state, state_next;

    logic [2:0]    byte_idx;
    logic [WW-1:0] word_idx;
    logic [SW-1:0] slot;
    logic [RW-1:0] row_cnt;
    logic          row_open;
    logic [55:0]   pack;

    logic       accept;
    logic       word_full;
    logic       last_word;
    logic       last_row;
    logic       slot_free;
    logic       rel_ok;
    logic [7:0] addr_next;

    assign accept    = pixel_valid && pixel_ready;
    assign word_full = accept && (byte_idx == 3'd7);
    assign last_word = (word_idx == WW'(WPR - 1));
    assign last_row  = (row_cnt == RW'(IMG_HEIGHT - 1));
    assign addr_next = 8'(slot) * 8'(WPR) + 8'(word_idx);
    assign rel_ok    = row_release && (rows_avail != 4'd0);
    // A row whose last word is being written (row_done high) still holds its slot
    // until rows_avail picks it up on the next edge.
    assign slot_free = ({1'b0, rows_avail} + {4'b0, row_done}) < 5'(NUM_ROWS_BUF);

    always_comb begin
        state_next  = state;
        pixel_ready = 1'b0;
        case (state)
            IDLE: state_next = IDLE;
            FILL: begin
                pixel_ready = !start && (row_open || slot_free);
                if (word_full && last_word && last_row) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (start) begin
            state_next = FILL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ena        <= 1'b0;
            wea        <= 1'b0;
            row_done   <= 1'b0;
            frame_done <= 1'b0;
            addra      <= 8'd0;
            dina       <= 64'd0;
            rows_avail <= 4'd0;
            byte_idx   <= 3'd0;
            word_idx   <= '0;
            slot       <= '0;
            row_cnt    <= '0;
            row_open   <= 1'b0;
            pack       <= 56'd0;
        end else begin
            ena        <= word_full;
            wea        <= word_full;
            row_done   <= word_full && last_word;
            frame_done <= word_full && last_word && last_row;
            if (start) begin
                rows_avail <= 4'd0;
                byte_idx   <= 3'd0;
                word_idx   <= '0;
                slot       <= '0;
                row_cnt    <= '0;
                row_open   <= 1'b0;
            end else begin
                if (row_done && !rel_ok && (rows_avail != 4'(NUM_ROWS_BUF))) begin
                    rows_avail <= rows_avail + 4'd1;
                end else if (rel_ok && !row_done) begin
                    rows_avail <= rows_avail - 4'd1;
                end

                if (word_full && last_word) begin
                    row_open <= 1'b0;
                end else if (accept) begin
                    row_open <= 1'b1;
                end

                if (accept) begin
                    byte_idx <= byte_idx + 3'd1;
                    for (int k = 0; k < 7; k++) begin
                        if (byte_idx == 3'(k)) begin
                            pack[8*k +: 8] <= pixel_data;
                        end
                    end
                    if (byte_idx == 3'd7) begin
                        addra <= addr_next;
                        dina  <= {pixel_data, pack};
                        if (last_word) begin
                            word_idx <= '0;
                            slot     <= (slot == SW'(NUM_ROWS_BUF - 1)) ? '0 : slot + 1'b1;
                            row_cnt  <= row_cnt + 1'b1;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_linebuf_writer.sv
// Bench for linebuf_writer: pixel-count model checked every cycle, plus directed literal checks.
module tb_linebuf_writer;
    localparam int W   = 64;
    localparam int H   = 64;
    localparam int NB  = 4;
    localparam int WPR = W / 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pixel_data = 8'd0;
    logic        pixel_valid = 1'b0;
    logic        row_release = 1'b0;
    logic        pixel_ready;
    logic        ena;
    logic        wea;
    logic [7:0]  addra;
    logic [63:0] dina;
    logic [3:0]  rows_avail;
    logic        row_done;
    logic        frame_done;

    int total = 0;
    int bad = 0;
    int fd_count = 0;
    int fd_base;

    linebuf_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .NUM_ROWS_BUF(NB)) dut (
        .clk(clk), .reset(reset), .start(start),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .row_release(row_release), .rows_avail(rows_avail),
        .row_done(row_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pixels accepted since start, rows credited to rows_avail, expected write port.
    int          m_px, m_rows_inc, m_avail, m_state;
    logic        m_ena, m_rd, m_fd;
    logic [7:0]  m_addr;
    logic [63:0] m_data;
    logic [7:0]  m_word [8];
    logic        hs, rd_prev;
    int          nav, w, row;

    function automatic logic exp_ready();
        logic new_row_ok;
        new_row_ok = ((m_px / W) - m_rows_inc + m_avail) < NB;
        return (m_state == 1) && !start && (((m_px % W) != 0) || new_row_ok);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_px = 0; m_rows_inc = 0; m_avail = 0; m_state = 0;
            m_ena = 1'b0; m_rd = 1'b0; m_fd = 1'b0; m_addr = 8'd0; m_data = 64'd0;
        end else begin
            hs = pixel_valid && exp_ready();
            rd_prev = m_rd;
            nav = m_avail;
            if (rd_prev) nav++;
            if (row_release && m_avail > 0) nav--;
            if (nav > NB) nav = NB;
            m_ena = 1'b0; m_rd = 1'b0; m_fd = 1'b0;
            if (start) begin
                m_px = 0; m_rows_inc = 0; m_avail = 0; m_state = 1;
            end else begin
                m_avail = nav;
                if (rd_prev) m_rows_inc++;
                if (hs) begin
                    m_word[m_px % 8] = pixel_data;
                    if (m_px % 8 == 7) begin
                        w = m_px / 8;
                        row = w / WPR;
                        m_ena = 1'b1;
                        m_addr = 8'((((row % NB) * WPR) + (w % WPR)) % 256);
                        for (int k = 0; k < 8; k++) m_data[8*k +: 8] = m_word[k];
                        m_rd = (w % WPR) == WPR - 1;
                        m_fd = m_rd && (row == H - 1);
                        if (m_fd) m_state = 2;
                    end
                    m_px++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("pixel_ready", pixel_ready, exp_ready());
            chk("ena", ena, m_ena);
            chk("wea", wea, m_ena);
            chk("addra", addra, m_addr);
            chk("dina", dina, m_data);
            chk("row_done", row_done, m_rd);
            chk("frame_done", frame_done, m_fd);
            chk("rows_avail", rows_avail, m_avail);
            if (frame_done) fd_count++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_px(input logic [7:0] d);
        logic got;
        int n;
        pixel_data = d;
        pixel_valid = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            got = pixel_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout: pixel_ready stayed 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic stream(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) send_px(8'(base + i));
        pixel_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        chk("ready_in_start_cycle", pixel_ready, 1'b0);
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_release();
        row_release = 1'b1;
        cyc();
        row_release = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        chk("rst_pixel_ready", pixel_ready, 1'b0);
        chk("rst_ena", ena, 1'b0);
        chk("rst_addra", addra, 8'd0);
        chk("rst_dina", dina, 64'd0);
        chk("rst_rows_avail", rows_avail, 4'd0);
        chk("rst_row_done", row_done, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // first word packing
        pulse_start();
        stream(8, 8'h01);
        chk("w0_ena", ena, 1'b1);
        chk("w0_wea", wea, 1'b1);
        chk("w0_addra", addra, 8'd0);
        chk("w0_dina", dina, 64'h0807060504030201);

        // one full row
        pulse_start();
        stream(64, 8'h10);
        chk("row0_addra", addra, 8'd7);
        chk("row0_row_done", row_done, 1'b1);
        chk("row0_avail_same", rows_avail, 4'd0);
        cyc();
        chk("row0_avail_next", rows_avail, 4'd1);

        // fill the ring, stall, release, slot wrap
        stream(3 * 64, 8'h20);
        cyc();
        chk("full_avail", rows_avail, 4'd4);
        chk("full_ready", pixel_ready, 1'b0);
        pixel_data = 8'hA0;
        pixel_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_ready", pixel_ready, 1'b0);
        end
        pulse_release();
        @(negedge clk);
        chk("release_ready", pixel_ready, 1'b1);
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        stream(7, 8'hA1);
        chk("wrap_addra", addra, 8'd0);
        chk("wrap_dina", dina, 64'hA7A6A5A4A3A2A1A0);
        stream(56, 8'hA8);
        chk("wrap_last_addra", addra, 8'd7);
        chk("wrap_row_done", row_done, 1'b1);

        // release coincident with row_done, release at zero
        pulse_start();
        stream(64, 8'h00);
        cyc();
        stream(64, 8'h40);
        chk("coinc_avail_before", rows_avail, 4'd1);
        pulse_release();
        chk("coinc_avail", rows_avail, 4'd1);
        cyc();
        chk("coinc_avail_hold", rows_avail, 4'd1);
        pulse_release();
        chk("release_to_zero", rows_avail, 4'd0);
        pulse_release();
        chk("release_at_zero", rows_avail, 4'd0);

        // full frame with release after each row
        fd_base = fd_count;
        pulse_start();
        for (int r = 0; r < H; r++) begin
            stream(64, 8'(r));
            chk("frame_row_done", row_done, 1'b1);
            chk("frame_done_flag", frame_done, r == H - 1);
            cyc();
            pulse_release();
        end
        chk("frame_done_count", fd_count - fd_base, 1);
        pixel_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("done_ready", pixel_ready, 1'b0);
            cyc();
        end
        pixel_valid = 1'b0;
        pulse_start();
        stream(8, 8'h11);
        chk("restart_ena", ena, 1'b1);
        chk("restart_addra", addra, 8'd0);

        // mid-row restart discards the partial word
        pulse_start();
        stream(19, 8'h30);
        pulse_start();
        stream(8, 8'h50);
        chk("midrow_addra", addra, 8'd0);
        chk("midrow_dina", dina, 64'h5756555453525150);
        stream(8, 8'h60);
        chk("prereset_ena", ena, 1'b1);
        chk("prereset_addra", addra, 8'd1);
        reset = 1'b1;
        #1;
        chk("async_ena", ena, 1'b0);
        chk("async_wea", wea, 1'b0);
        chk("async_addra", addra, 8'd0);
        chk("async_dina", dina, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc();
        chk("idle_ready", pixel_ready, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
